// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between a memory requester and mem_responder
interface mem_responder_if;
    logic        Req;
    logic        Wr;
    logic [31:0] Address;
    logic [31:0] Datain;
    logic [31:0] Dataout;
    logic        Ready;
    logic        Busy;
    logic        Error;

    modport master (output Req, Wr, Address, Datain, input Dataout, Ready, Busy, Error);
    modport slave  (input Req, Wr, Address, Datain, output Dataout, Ready, Busy, Error);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory slave with programmable wait states and a one-cycle Ready pulse.
// Optional feature: define MEM_RESP_ALIGN_CHECK_EN to flag misaligned accesses via Error and suppress their effect.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input logic            Clk,
    input logic            Reset,
    mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
`ifdef MEM_RESP_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          wr_q, wr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          mis_q, mis_d;
    logic [31:0]   dout_q, dout_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [31:0]   mem_q [DEPTH_WORDS];
    logic          we;

    assign bus.Dataout = dout_q;
    assign bus.Ready   = ready_q;
    assign bus.Busy    = busy_q;
    assign bus.Error   = err_q;
    assign we          = state_q == ACCESS && wr_q && !mis_q && !Reset;

    // state and output registers; reset aborts any request in flight
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
            dout_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // storage array: not reset, written only on the ACCESS edge of an accepted write
    always_ff @(posedge Clk) begin
        if (we) mem_q[idx_q] <= wdata_q;
    end

    // next-state, request latching and registered output values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        mis_d   = mis_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: if (bus.Req) begin
                idx_d   = bus.Address[AW+1:2];
                wr_d    = bus.Wr;
                wdata_d = bus.Datain;
                mis_d   = ALIGN_CHECK && bus.Address[1:0] != 2'b00;
                cnt_d   = 4'(WAIT_CYCLES);
                state_d = WAIT_CYCLES == 0 ? ACCESS : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = cnt_q == 4'd1 ? ACCESS : WAIT;
            end
            ACCESS: begin
                dout_d  = mis_q ? 32'd0 : (wr_q ? wdata_q : mem_q[idx_q]);
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
        ready_d = state_d == RESP;
        busy_d  = state_d != IDLE;
        err_d   = state_d == RESP && mis_q;
    end
endmodule
